// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MEM/WB boundary: write-back source select, load size,
// and the default control-bundle positions of the RF/HI/LO write enables.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    WB_ALU   = 2'b00,
    WB_MEM   = 2'b01,
    WB_LINK  = 2'b10,
    WB_ALU_X = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    SZ_WORD   = 2'b00,
    SZ_HALF   = 2'b01,
    SZ_BYTE   = 2'b10,
    SZ_WORD_X = 2'b11
  } mem_size_e;

  localparam int ALIGN_W       = 32;
  localparam int RF_EN_BIT_DEF = 9;
  localparam int HI_EN_BIT_DEF = 2;
  localparam int LO_EN_BIT_DEF = 1;

endpackage

// File: rtl/load_align.sv
// Big-endian sub-word extraction and sign/zero extension of a raw memory word.
// Purely combinational; the pipeline register sits downstream.
module load_align
  import mips_pipe_pkg::*;
(
  input  logic [ALIGN_W-1:0] word_i,
  input  logic [1:0]         offset_i,
  input  logic [1:0]         size_i,
  input  logic               signed_i,
  output logic [ALIGN_W-1:0] value_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    case (offset_i)
      2'd0:    byte_v = word_i[31:24];
      2'd1:    byte_v = word_i[23:16];
      2'd2:    byte_v = word_i[15:8];
      default: byte_v = word_i[7:0];
    endcase

    // offset bit 0 is deliberately ignored for half-word loads
    half_v = offset_i[1] ? word_i[15:0] : word_i[31:16];

    value_o = word_i;
    case (size_i)
      SZ_HALF: value_o = {{16{signed_i & half_v[15]}}, half_v};
      SZ_BYTE: value_o = {{24{signed_i & byte_v[7]}}, byte_v};
      default: value_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: selects and aligns the write-back value, qualifies
// register-file/HI/LO enables, and counts retired instructions.
module mem_wb_pipe_reg
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 22,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 32,
  parameter int RF_EN_BIT = RF_EN_BIT_DEF,
  parameter int HI_EN_BIT = HI_EN_BIT_DEF,
  parameter int LO_EN_BIT = LO_EN_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] link_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [1:0]        wb_sel,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              rf_we,
  output logic              hi_we,
  output logic              lo_we,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic [DATA_W-1:0] mem_aligned;
  logic [DATA_W-1:0] wb_value;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [REG_AW-1:0] rd_q,    rd_d;
  logic              rf_q,    rf_d;
  logic              hi_q,    hi_d;
  logic              lo_q,    lo_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  load_align u_load_align (
    .word_i   (mem_data_in),
    .offset_i (alu_in[1:0]),
    .size_i   (mem_size),
    .signed_i (mem_signed),
    .value_o  (mem_aligned)
  );

  always_comb begin
    wb_value = alu_in;
    case (wb_sel)
      WB_MEM:  wb_value = mem_aligned;
      WB_LINK: wb_value = link_in;
      default: wb_value = alu_in;
    endcase
  end

  // Flush clears only the qualifiers and control; data and rd are left as-is.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    rd_d    = rd_q;
    rf_d    = rf_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rf_d    = 1'b0;
      hi_d    = 1'b0;
      lo_d    = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      ctrl_d  = ctrl_in;
      data_d  = wb_value;
      rd_d    = rd_in;
      rf_d    = ctrl_in[RF_EN_BIT] & in_valid & (rd_in != '0);
      hi_d    = ctrl_in[HI_EN_BIT] & in_valid;
      lo_d    = ctrl_in[LO_EN_BIT] & in_valid;
      if (in_valid) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      rf_q    <= 1'b0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      rf_q    <= rf_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_valid   = valid_q;
  assign ctrl_out   = ctrl_q;
  assign wb_data    = data_q;
  assign wb_rd      = rd_q;
  assign rf_we      = rf_q;
  assign hi_we      = hi_q;
  assign lo_we      = lo_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: directed scenarios plus random traffic against a
// behavioural model; a CNT_W=4 instance shares the stimulus to exercise wrap.
module tb_mem_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid, mem_signed;
  logic [21:0] ctrl_in;
  logic [31:0] alu_in, mem_data_in, link_in;
  logic [4:0]  rd_in;
  logic [1:0]  wb_sel, mem_size;

  logic        wb_valid, rf_we, hi_we, lo_we;
  logic [21:0] ctrl_out;
  logic [31:0] wb_data, retire_cnt;
  logic [4:0]  wb_rd;

  logic        wb_valid4, rf_we4, hi_we4, lo_we4;
  logic [21:0] ctrl_out4;
  logic [31:0] wb_data4;
  logic [4:0]  wb_rd4;
  logic [3:0]  retire_cnt4;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic        m_valid, m_rf, m_hi, m_lo;
  logic [21:0] m_ctrl;
  logic [31:0] m_data;
  logic [4:0]  m_rd;
  longint      m_cnt;
  int          m_cnt4;

  always #5 clk = ~clk;

  mem_wb_pipe_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .ctrl_in(ctrl_in), .alu_in(alu_in), .mem_data_in(mem_data_in), .link_in(link_in),
    .rd_in(rd_in), .wb_sel(wb_sel), .mem_size(mem_size), .mem_signed(mem_signed),
    .wb_valid(wb_valid), .ctrl_out(ctrl_out), .wb_data(wb_data), .wb_rd(wb_rd),
    .rf_we(rf_we), .hi_we(hi_we), .lo_we(lo_we), .retire_cnt(retire_cnt)
  );

  mem_wb_pipe_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .ctrl_in(ctrl_in), .alu_in(alu_in), .mem_data_in(mem_data_in), .link_in(link_in),
    .rd_in(rd_in), .wb_sel(wb_sel), .mem_size(mem_size), .mem_signed(mem_signed),
    .wb_valid(wb_valid4), .ctrl_out(ctrl_out4), .wb_data(wb_data4), .wb_rd(wb_rd4),
    .rf_we(rf_we4), .hi_we(hi_we4), .lo_we(lo_we4), .retire_cnt(retire_cnt4)
  );

  function automatic logic [31:0] load_value(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] sz, input logic sgn);
    longint v;
    if (sz == 2'b01) begin
      v = off[1] ? (w & 32'hFFFF) : (w >> 16);
      if (sgn && v >= 'h8000) v = v + 64'hFFFF0000;
    end else if (sz == 2'b10) begin
      v = (w >> (8 * (3 - off))) & 32'hFF;
      if (sgn && v >= 'h80) v = v + 64'hFFFFFF00;
    end else begin
      v = w;
    end
    return v[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance the model with the current inputs, clock, then compare both DUTs
  task automatic step();
    if (reset) begin
      m_valid = 0; m_rf = 0; m_hi = 0; m_lo = 0;
      m_ctrl = 0; m_data = 0; m_rd = 0; m_cnt = 0; m_cnt4 = 0;
    end else if (flush) begin
      m_valid = 0; m_rf = 0; m_hi = 0; m_lo = 0; m_ctrl = 0;
    end else if (!stall) begin
      if (wb_sel == 2'b01)      m_data = load_value(mem_data_in, alu_in[1:0], mem_size, mem_signed);
      else if (wb_sel == 2'b10) m_data = link_in;
      else                      m_data = alu_in;
      m_valid = in_valid;
      m_ctrl  = ctrl_in;
      m_rd    = rd_in;
      m_rf    = ctrl_in[9] && in_valid && (rd_in != 0);
      m_hi    = ctrl_in[2] && in_valid;
      m_lo    = ctrl_in[1] && in_valid;
      if (in_valid) begin
        m_cnt  = (m_cnt + 1) % 64'h1_0000_0000;
        m_cnt4 = (m_cnt4 + 1) % 16;
      end
    end
    @(posedge clk);
    #1;
    chk("wb_valid", wb_valid, m_valid);
    chk("ctrl_out", ctrl_out, m_ctrl);
    chk("wb_data", wb_data, m_data);
    chk("wb_rd", wb_rd, m_rd);
    chk("rf_we", rf_we, m_rf);
    chk("hi_we", hi_we, m_hi);
    chk("lo_we", lo_we, m_lo);
    chk("retire_cnt", retire_cnt, m_cnt[31:0]);
    chk("retire_cnt4", retire_cnt4, m_cnt4[3:0]);
    chk("wb_data4", wb_data4, m_data);
  endtask

  task automatic randomize_inputs();
    ctrl_in     = 22'($urandom);
    alu_in      = $urandom;
    mem_data_in = $urandom;
    link_in     = $urandom;
    rd_in       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    wb_sel      = 2'($urandom);
    mem_size    = 2'($urandom);
    mem_signed  = 1'($urandom);
  endtask

  initial begin
    logic [31:0] held_data;
    logic [31:0] held_cnt;

    reset = 1; stall = 0; flush = 0; in_valid = 0;
    randomize_inputs();
    m_cnt = 0; m_cnt4 = 0;
    step();
    chk("reset_valid", wb_valid, 1'b0);
    chk("reset_cnt", retire_cnt, 32'd0);
    reset = 0;

    // word load
    in_valid = 1; wb_sel = 2'b01; mem_size = 2'b00; mem_data_in = 32'h8899AABB;
    alu_in = 32'h0000_0003; mem_signed = 1;
    step();
    chk("word_data", wb_data, 32'h8899AABB);
    chk("word_valid", wb_valid, 1'b1);
    chk("word_cnt", retire_cnt, 32'd1);

    // byte loads, signed and unsigned
    mem_data_in = 32'h11F23344; alu_in = 32'h0000_1001; mem_size = 2'b10; mem_signed = 1;
    step();
    chk("byte_signed", wb_data, 32'hFFFFFFF2);
    mem_signed = 0;
    step();
    chk("byte_unsigned", wb_data, 32'h000000F2);

    // half load, low half, signed; bit 0 of offset set to show it is ignored
    mem_data_in = 32'h0000807F; alu_in = 32'h0000_0003; mem_size = 2'b01; mem_signed = 1;
    step();
    chk("half_signed", wb_data, 32'hFFFF807F);

    // register-0 write suppression
    ctrl_in = 22'h000200; rd_in = 5'd0; wb_sel = 2'b00;
    step();
    chk("rd0_rf_we", rf_we, 1'b0);
    chk("rd0_valid", wb_valid, 1'b1);
    rd_in = 5'd5;
    step();
    chk("rd5_rf_we", rf_we, 1'b1);
    chk("rd5_wb_rd", wb_rd, 5'd5);

    // stall three cycles with changing inputs
    held_data = wb_data; held_cnt = retire_cnt;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      in_valid = 1;
      step();
    end
    chk("stall_data", wb_data, held_data);
    chk("stall_cnt", retire_cnt, held_cnt);

    // stall and flush together
    flush = 1; ctrl_in = 22'h3FFFFF;
    step();
    chk("flush_valid", wb_valid, 1'b0);
    chk("flush_rf", rf_we, 1'b0);
    chk("flush_hilo", {hi_we, lo_we}, 2'b00);
    chk("flush_data_held", wb_data, held_data);
    stall = 0; flush = 0;

    // reset with stall and valid input mid-stream
    step();
    reset = 1; stall = 1; in_valid = 1;
    step();
    chk("rst_stall_data", wb_data, 32'd0);
    chk("rst_stall_cnt", retire_cnt, 32'd0);
    reset = 0; stall = 0;

    // 16 valid loads wrap the 4-bit counter
    for (int i = 1; i <= 16; i++) begin
      randomize_inputs();
      in_valid = 1;
      step();
      if (i == 15) chk("cnt4_all_ones", retire_cnt4, 4'hF);
    end
    chk("cnt4_wrap", retire_cnt4, 4'h0);
    chk("cnt32_16", retire_cnt, 32'd16);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      reset    = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe_reg.md
MEM_WB_PIPE_REG -- requirements
Module: mem_wb_pipe_reg

Interface
REQ-001 Params (name, default, meaning), one per line:
  DATA_W  32  datapath width; REQ-019 fixes 32 for this revision.
  CTRL_W  22  control bundle width.
  REG_AW  5   register-address width.
  CNT_W   32  retire-counter width.
  RF_EN_BIT  9  ctrl bit for RF write enable.
  HI_EN_BIT  2  ctrl bit for HI write enable.
  LO_EN_BIT  1  ctrl bit for LO write enable.
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, rising edge.
  reset  in  1  synchronous, active-high.
  stall  in  1  hold current WB contents.
  flush  in  1  replace WB contents with bubble.
  in_valid  in  1  MEM stage holds a real instruction.
  ctrl_in  in  CTRL_W  MEM control bundle.
  alu_in  in  DATA_W  ALU result; bits [1:0] are the load address offset.
  mem_data_in  in  DATA_W  raw data-memory word.
  link_in  in  DATA_W  link value (PC+8).
  rd_in  in  REG_AW  destination register.
  wb_sel  in  2  00 ALU, 01 MEM, 10 LINK, 11 ALU.
  mem_size  in  2  00 word, 01 half, 10 byte, 11 word.
  mem_signed  in  1  sign-extend sub-word loads.
  wb_valid  out  1  WB holds a real instruction.
  ctrl_out  out  CTRL_W  registered ctrl_in.
  wb_data  out  DATA_W  registered write-back value.
  wb_rd  out  REG_AW  registered rd_in.
  rf_we  out  1  qualified RF write enable.
  hi_we  out  1  qualified HI write enable.
  lo_we  out  1  qualified LO write enable.
  retire_cnt  out  CNT_W  retired-instruction count.
REQ-003 All outputs SHALL be driven directly from registers; no combinational input-to-output path.

Function
REQ-004 Update priority each rising clk edge SHALL be: reset > flush > stall > load.
REQ-005 Load: capture ctrl_in, rd_in and the selected and aligned write-back value; set wb_valid=in_valid; latency exactly one cycle.
REQ-006 Stall without flush: every register holds its value, including the enables; retire_cnt SHALL NOT increment.
REQ-007 Flush (stall ignored): wb_valid=0, rf_we=hi_we=lo_we=0, ctrl_out=0; wb_data and wb_rd hold their values.
REQ-008 rf_we SHALL load as ctrl_in[RF_EN_BIT] & in_valid & (rd_in!=0); a write to register 0 is suppressed.
REQ-009 hi_we and lo_we SHALL load as ctrl_in[HI_EN_BIT] & in_valid and ctrl_in[LO_EN_BIT] & in_valid respectively.
REQ-010 wb_sel 00 and 11 SHALL select alu_in, 01 the aligned memory value, 10 link_in.
REQ-011 Alignment is big-endian: byte k occupies mem_data_in[31-8k:24-8k], k=alu_in[1:0].
REQ-012 Half-word loads SHALL use alu_in[1] only: 0 selects [31:16], 1 selects [15:0]; alu_in[0] is ignored.
REQ-013 Sub-word values SHALL be sign-extended if mem_signed=1, else zero-extended; word loads ignore alu_in[1:0] and mem_signed.
REQ-014 retire_cnt SHALL increment by 1 on each load with in_valid=1 and wrap from all-ones to 0.
REQ-015 A load with in_valid=0 SHALL insert a bubble: wb_valid=0, all enables 0, data fields loaded normally.

Reset
REQ-016 While reset=1 at a clk edge, all outputs SHALL be cleared: wb_valid, enables, ctrl_out, wb_data, wb_rd, retire_cnt = 0.
REQ-017 Reset SHALL override simultaneous stall, flush or in_valid; the first post-reset edge with reset=0 behaves per REQ-004.

Structure
REQ-018 Shared package mips_pipe_pkg SHALL hold the wb_sel and mem_size encodings and the default RF/HI/LO enable bit positions.
REQ-019 Sub-module load_align SHALL implement REQ-011..013 combinationally (inputs: word, offset, size, signed; output: DATA_W value); DATA_W fixed at 32 for alignment in this revision.

Verification
REQ-020 Word load: wb_sel=01, size=00, mem_data_in=0x8899AABB, in_valid=1 -> next cycle wb_data=0x8899AABB, wb_valid=1, retire_cnt=1.
REQ-021 Byte load: mem_data_in=0x11F23344, alu_in[1:0]=01, size=10 -> signed gives 0xFFFFFFF2, unsigned gives 0x000000F2; half with alu_in[1]=1, signed, data 0x0000807F -> 0xFFFF807F.
REQ-022 rd_in=0, ctrl_in[9]=1, in_valid=1 -> rf_we=0, wb_valid=1; same with rd_in=5 -> rf_we=1, wb_rd=5.
REQ-023 Stall 3 cycles with changing inputs -> outputs and retire_cnt frozen; stall and flush together -> wb_valid=0, all enables 0.
REQ-024 retire_cnt preset to all-ones via valid loads (CNT_W=4 build) -> 16th valid load gives 0; reset asserted mid-stream together with stall -> all outputs 0 next cycle.
